// File: rtl/gpu_mcnt_pkg.sv
// Shared definitions for the GPU packet master-count generator.
package gpu_mcnt_pkg;

    localparam int unsigned MCNT_W_DEF        = 48;
    localparam int unsigned PKTS_PER_SYNC_DEF = 2048;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } mcnt_state_t;

endpackage

// File: rtl/edge_rise.sv
// One-bit registered rising-edge detector with asynchronous reset.
// The first cycle after reset release never reports an edge, so a level
// already high while reset was asserted is not mistaken for a fresh edge.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic sig_q,
    output logic rise
);

    logic primed_q;

    // Track the previous level and whether a valid previous level exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            sig_q    <= sig;
            primed_q <= 1'b1;
        end
    end

    assign rise = sig & ~sig_q & primed_q;

endmodule

// File: rtl/gpu_mcnt_gen.sv
// GPU packet master count generator: armed by software, zeroed on the
// following sync, incremented per completed packet, with sync phase checking
// and a coherent snapshot for the software register.
module gpu_mcnt_gen
    import gpu_mcnt_pkg::*;
#(
    parameter int unsigned MCNT_W        = MCNT_W_DEF,
    parameter int unsigned PKTS_PER_SYNC = PKTS_PER_SYNC_DEF,
    parameter int unsigned PH_W          = $clog2(PKTS_PER_SYNC)
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              arm_in,
    input  logic              sync_in,
    input  logic              pkt_done,
    input  logic              snap_req,
    output logic [MCNT_W-1:0] mcnt,
    output logic [31:0]       mcnt_lsb,
    output logic [MCNT_W-33:0] mcnt_msb,
    output logic              armed,
    output logic              running,
    output logic              sync_err,
    output logic [31:0]       sync_cnt
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PKTS_PER_SYNC - 1);

    logic arm_q, arm_rise;
    logic sync_q, sync_rise;

    mcnt_state_t       state_q, state_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [MCNT_W-1:0] snap_q, snap_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              err_q, err_d;
    logic [31:0]       sync_cnt_q, sync_cnt_d;
    // Set when ARMED was entered from RUN: counting carries on while waiting
    // for the re-zeroing sync.
    logic              carry_q, carry_d;

    edge_rise u_arm_edge (
        .clk  (user_clk),
        .rst  (user_rst),
        .sig  (arm_in),
        .sig_q(arm_q),
        .rise (arm_rise)
    );

    edge_rise u_sync_edge (
        .clk  (user_clk),
        .rst  (user_rst),
        .sig  (sync_in),
        .sig_q(sync_q),
        .rise (sync_rise)
    );

    // Next-state logic for the FSM, count, phase check and snapshot.
    always_comb begin
        state_d    = state_q;
        mcnt_d     = mcnt_q;
        phase_d    = phase_q;
        err_d      = err_q;
        carry_d    = carry_q;
        sync_cnt_d = sync_cnt_q + {31'd0, sync_rise};
        // Snapshot always takes the pre-update count.
        snap_d     = snap_req ? mcnt_q : snap_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arm_rise) begin
                    state_d = ST_ARMED;
                    carry_d = 1'b0;
                end
            end
            ST_ARMED: begin
                // A coincident packet is dropped in favour of the zeroing sync.
                if (sync_rise) begin
                    state_d = ST_RUN;
                    mcnt_d  = '0;
                    phase_d = '0;
                    err_d   = 1'b0;
                end else if (pkt_done && carry_q) begin
                    mcnt_d = mcnt_q + MCNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sync_rise && (phase_q != '0)) begin
                    err_d = 1'b1;
                end
                if (pkt_done) begin
                    mcnt_d  = mcnt_q + MCNT_W'(1);
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                end
                // Re-arm ignores a same-cycle sync; the next sync re-zeroes.
                if (arm_rise) begin
                    state_d = ST_ARMED;
                    carry_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q    <= ST_IDLE;
            mcnt_q     <= '0;
            snap_q     <= '0;
            phase_q    <= '0;
            err_q      <= 1'b0;
            sync_cnt_q <= '0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcnt_q     <= mcnt_d;
            snap_q     <= snap_d;
            phase_q    <= phase_d;
            err_q      <= err_d;
            sync_cnt_q <= sync_cnt_d;
            carry_q    <= carry_d;
        end
    end

    assign mcnt     = mcnt_q;
    assign mcnt_lsb = snap_q[31:0];
    assign mcnt_msb = snap_q[MCNT_W-1:32];
    assign armed    = (state_q == ST_ARMED);
    assign running  = (state_q == ST_RUN);
    assign sync_err = err_q;
    assign sync_cnt = sync_cnt_q;

endmodule

// File: tb/tb_gpu_mcnt_gen.sv
// Self-checking bench for gpu_mcnt_gen with a behavioural reference model.
module tb_gpu_mcnt_gen;

    localparam int unsigned MW   = 48;
    localparam int unsigned PKTS = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;

    logic          user_clk = 1'b0;
    logic          user_rst = 1'b1;
    logic          arm_in   = 1'b0;
    logic          sync_in  = 1'b0;
    logic          pkt_done = 1'b0;
    logic          snap_req = 1'b0;
    logic [MW-1:0] mcnt;
    logic [31:0]   mcnt_lsb;
    logic [MW-33:0] mcnt_msb;
    logic          armed;
    logic          running;
    logic          sync_err;
    logic [31:0]   sync_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int            m_state;
    logic [MW-1:0] m_mcnt;
    logic [MW-1:0] m_snap;
    int            m_pk;
    logic          m_err;
    logic [31:0]   m_scnt;
    logic          m_carry;
    logic          m_pa;
    logic          m_ps;

    gpu_mcnt_gen #(
        .MCNT_W       (MW),
        .PKTS_PER_SYNC(PKTS)
    ) dut (
        .user_clk(user_clk),
        .user_rst(user_rst),
        .arm_in  (arm_in),
        .sync_in (sync_in),
        .pkt_done(pkt_done),
        .snap_req(snap_req),
        .mcnt    (mcnt),
        .mcnt_lsb(mcnt_lsb),
        .mcnt_msb(mcnt_msb),
        .armed   (armed),
        .running (running),
        .sync_err(sync_err),
        .sync_cnt(sync_cnt)
    );

    always #5 user_clk = ~user_clk;

    // Levels present at reset release count as already seen.
    task automatic model_reset();
        m_state = M_IDLE;
        m_mcnt  = '0;
        m_snap  = '0;
        m_pk    = 0;
        m_err   = 1'b0;
        m_scnt  = '0;
        m_carry = 1'b0;
        m_pa    = 1'b1;
        m_ps    = 1'b1;
    endtask

    task automatic model_step(input logic a, input logic s, input logic p, input logic r);
        logic ar;
        logic sr;
        ar   = a && !m_pa;
        sr   = s && !m_ps;
        m_pa = a;
        m_ps = s;
        if (r) m_snap = m_mcnt;
        if (sr) m_scnt = m_scnt + 32'd1;
        case (m_state)
            M_IDLE: begin
                if (ar) begin
                    m_state = M_ARMED;
                    m_carry = 1'b0;
                end
            end
            M_ARMED: begin
                if (sr) begin
                    m_state = M_RUN;
                    m_mcnt  = '0;
                    m_pk    = 0;
                    m_err   = 1'b0;
                end else if (p && m_carry) begin
                    m_mcnt = m_mcnt + 1'b1;
                end
            end
            default: begin
                if (sr && (m_pk % PKTS) != 0) m_err = 1'b1;
                if (p) begin
                    m_mcnt = m_mcnt + 1'b1;
                    m_pk   = (m_pk + 1) % PKTS;
                end
                if (ar) begin
                    m_state = M_ARMED;
                    m_carry = 1'b1;
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs, advance the model, land at the sample point.
    task automatic cycle(input logic a, input logic s, input logic p, input logic r);
        arm_in   = a;
        sync_in  = s;
        pkt_done = p;
        snap_req = r;
        model_step(a, s, p, r);
        @(posedge user_clk);
        #1;
    endtask

    task automatic rst_assert();
        user_rst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic rst_release();
        @(posedge user_clk);
        #1;
        user_rst = 1'b0;
    endtask

    function automatic logic [130:0] dut_vec();
        return {mcnt, mcnt_lsb, mcnt_msb, armed, running, sync_err, sync_cnt};
    endfunction

    function automatic logic [130:0] model_vec();
        logic a;
        logic r;
        a = (m_state == M_ARMED);
        r = (m_state == M_RUN);
        return {m_mcnt, m_snap[31:0], m_snap[MW-1:32], a, r, m_err, m_scnt};
    endfunction

    task automatic test_reset();
        rst_assert();
        repeat (3) @(posedge user_clk);
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", dut_vec());
        end
        rst_release();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (mcnt !== '0 || running !== 1'b0 || armed !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores_pkts mcnt=%0d running=%b armed=%b want 0/0/0",
                     mcnt, running, armed);
        end
    endtask

    task automatic test_arm_count();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (armed !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL arm armed=%b running=%b want 1/0", armed, running);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b1 || mcnt !== '0 || sync_cnt !== 32'd1) begin
            failures++;
            $display("FAIL sync_start running=%b mcnt=%0d sync_cnt=%0d want 1/0/1",
                     running, mcnt, sync_cnt);
        end
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (mcnt !== 48'd5) begin
            failures++;
            $display("FAIL count5 mcnt=%0d want 5", mcnt);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (mcnt_lsb !== 32'd5 || mcnt_msb !== '0) begin
            failures++;
            $display("FAIL snap5 lsb=%0d msb=%0d want 5/0", mcnt_lsb, mcnt_msb);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_phase();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            if (k == 4 || k == 8) begin
                cycle(1'b1, 1'b1, 1'b0, 1'b0);
                cycle(1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
        checks++;
        if (sync_err !== 1'b0 || mcnt !== 48'd8) begin
            failures++;
            $display("FAIL phase_aligned err=%b mcnt=%0d want 0/8", sync_err, mcnt);
        end
        for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sync_err !== 1'b1) begin
            failures++;
            $display("FAIL phase_misaligned err=%b want 1", sync_err);
        end
        for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || mcnt !== 48'd12 || sync_cnt !== m_scnt) begin
            failures++;
            $display("FAIL err_sticky err=%b mcnt=%0d sync_cnt=%0d want 1/12/%0d",
                     sync_err, mcnt, sync_cnt, m_scnt);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sync_err !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL rearm_clears err=%b running=%b want 0/1", sync_err, running);
        end
        force dut.mcnt_q = 48'hFFFF_FFFF_FFFF;
        #1;
        release dut.mcnt_q;
        m_mcnt = 48'hFFFF_FFFF_FFFF;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (mcnt !== '0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL wrap mcnt=%h err=%b want 0/0", mcnt, sync_err);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (mcnt_lsb !== '0 || mcnt_msb !== '0) begin
            failures++;
            $display("FAIL wrap_snap lsb=%h msb=%h want 0/0", mcnt_lsb, mcnt_msb);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (running !== 1'b1 || mcnt !== '0) begin
            failures++;
            $display("FAIL sync_beats_pkt running=%b mcnt=%0d want 1/0", running, mcnt);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (armed !== 1'b1 || running !== 1'b0 || mcnt !== 48'd4) begin
            failures++;
            $display("FAIL rearm_same_sync armed=%b running=%b mcnt=%0d want 1/0/4",
                     armed, running, mcnt);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (armed !== 1'b1 || mcnt !== 48'd5) begin
            failures++;
            $display("FAIL armed_keeps_count armed=%b mcnt=%0d want 1/5", armed, mcnt);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b1 || mcnt !== '0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL next_sync_zero running=%b mcnt=%0d err=%b want 1/0/0",
                     running, mcnt, sync_err);
        end
    endtask

    task automatic test_reset_midrun();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (mcnt !== 48'd100 || running !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset mcnt=%0d running=%b want 100/1", mcnt, running);
        end
        rst_assert();
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", dut_vec());
        end
        @(posedge user_clk);
        rst_release();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (armed !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL held_arm armed=%b running=%b want 0/0", armed, running);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (armed !== 1'b1) begin
            failures++;
            $display("FAIL fresh_arm armed=%b want 1", armed);
        end
    endtask

    task automatic test_random();
        logic a;
        logic s;
        logic p;
        logic r;
        int   errs;
        a    = arm_in;
        s    = sync_in;
        errs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                rst_assert();
                @(posedge user_clk);
                rst_release();
            end
            if ($urandom_range(0, 15) == 0) a = ~a;
            if ($urandom_range(0, 5) == 0) s = ~s;
            p = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 7) == 0);
            cycle(a, s, p, r);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                if (errs < 10) begin
                    $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), model_vec());
                end
                errs++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_arm_count();
        test_phase();
        test_wrap();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
